// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bridge state and request types for the AHB to
// PicoRV32 native memory bridge.
package ahb_pkg;

  localparam int unsigned AHB_AW = 32;
  localparam int unsigned AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  // Address-phase payload kept for the data phase; strobes are resolved at capture.
  typedef struct packed {
    logic [AHB_AW-1:2] word_addr;
    logic              write;
    logic              instr;
    logic [3:0]        wstrb;
  } ahb_req_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ahb_picorv32_mem_bridge_if.sv
// AHB-Lite slave port plus PicoRV32 native memory port of the bridge.
interface ahb_picorv32_mem_bridge_if;
  import ahb_pkg::*;

  logic              hsel;
  logic [AHB_AW-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [AHB_DW-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [AHB_DW-1:0] hrdata;

  logic              mem_valid;
  logic              mem_instr;
  logic              mem_ready;
  logic [AHB_AW-1:0] mem_addr;
  logic [AHB_DW-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [AHB_DW-1:0] mem_rdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/ahb_picorv32_lane_map.sv
// Combinational byte-lane mapping, strobe generation and size/alignment check.
module ahb_picorv32_lane_map
  import ahb_pkg::*;
#(
  parameter bit BIG_ENDIAN_AHB = 1'b1
) (
  input  logic [2:0]  hsize,
  input  logic [1:0]  addr,
  input  logic [31:0] hwdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] mem_wdata,
  output logic [31:0] hrdata,
  output logic        illegal
);

  always_comb begin
    wstrb   = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: wstrb = 4'b0001 << addr;
      HSIZE_HALF: begin
        wstrb   = 4'b0011 << addr;
        illegal = addr[0];
      end
      HSIZE_WORD: begin
        wstrb   = 4'b1111;
        illegal = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Native side is always little-endian; GRLIB AHB puts offset 0 on the top lane.
  assign mem_wdata = BIG_ENDIAN_AHB ? byteswap32(hwdata)    : hwdata;
  assign hrdata    = BIG_ENDIAN_AHB ? byteswap32(mem_rdata) : mem_rdata;

endmodule

// File: rtl/ahb_picorv32_mem_bridge.sv
// AHB-Lite slave that reissues each transfer as one PicoRV32 native memory request.
module ahb_picorv32_mem_bridge
  import ahb_pkg::*;
#(
  parameter bit          BIG_ENDIAN_AHB = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input logic                      clk,
  input logic                      reset,
  ahb_picorv32_mem_bridge_if.slave bus
);

  bridge_state_e        state_q, state_d;
  ahb_req_t             req_q, req_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 hreadyout_q, hreadyout_d;
  logic                 hresp_q, hresp_d;
  logic [31:0]          hrdata_q, hrdata_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_instr_q, mem_instr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_wstrb_q, mem_wstrb_d;

  logic [3:0]           lane_wstrb;
  logic [31:0]          lane_wdata;
  logic [31:0]          lane_rdata;
  logic                 lane_illegal;
  logic                 capture;
  logic                 timeout;

  ahb_picorv32_lane_map #(
    .BIG_ENDIAN_AHB (BIG_ENDIAN_AHB)
  ) u_lane_map (
    .hsize     (bus.hsize),
    .addr      (bus.haddr[1:0]),
    .hwdata    (bus.hwdata),
    .mem_rdata (bus.mem_rdata),
    .wstrb     (lane_wstrb),
    .mem_wdata (lane_wdata),
    .hrdata    (lane_rdata),
    .illegal   (lane_illegal)
  );

  assign capture = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
  assign timeout = (TIMEOUT_CYCLES != 0) &&
                   (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    tmo_d       = '0;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      ST_SETUP: begin
        if (req_q.write) mem_wdata_d = lane_wdata;
        mem_addr_d  = {req_q.word_addr, 2'b00};
        mem_instr_d = req_q.instr;
        mem_wstrb_d = req_q.write ? req_q.wstrb : 4'b0000;
        mem_valid_d = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          if (!req_q.write) hrdata_d = lane_rdata;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
          state_d     = ST_RESP;
        end else if (timeout) begin
          mem_valid_d = 1'b0;
          hresp_d     = HRESP_ERROR;
          state_d     = ST_ERR1;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      ST_ERR1: begin
        hresp_d     = HRESP_ERROR;
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      default: begin
        // IDLE, RESP and ERR2 all present hreadyout=1 and may accept a new address phase.
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        state_d     = ST_IDLE;
        if (capture) begin
          req_d.word_addr = bus.haddr[31:2];
          req_d.write     = bus.hwrite;
          req_d.instr     = ~bus.hprot[0];
          req_d.wstrb     = lane_wstrb;
          hreadyout_d     = 1'b0;
          if (lane_illegal) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      tmo_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      tmo_q       <= tmo_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_instr = mem_instr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/ahb_picorv32_mem_bridge.md
Name: ahb_picorv32_mem_bridge

Overview:
AHB-Lite slave that accepts AHB transfers and reissues each one as a single PicoRV32 native memory request (valid/ready, wstrb) towards a native-interface memory or peripheral. It is the responder-side counterpart of the core-side native-to-FreeAHB adapter. With it, native-interface RAMs and peripherals can hang off the GRLIB AHB bus unchanged. It handles byte-lane mapping for either bus endianness, wait-state generation, and error responses.

Parameters:
BIG_ENDIAN_AHB, 1, 1 = GRLIB big-endian byte lanes (full byte swap between AHB and native side); 0 = little-endian pass-through.
TIMEOUT_CYCLES, 0, maximum cycles mem_valid stays high without mem_ready before an ERROR response; 0 disables the timeout.
TIMEOUT_W, 16, width of the timeout counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
hsel  in  1  slave select.
haddr  in  32  address-phase address.
htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
hwrite  in  1  1 = write.
hsize  in  3  transfer size: 000 byte, 001 half, 010 word; larger is illegal.
hprot  in  4  protection; hprot[0]=0 marks an opcode fetch.
hwdata  in  32  write data, valid in the data phase.
hready  in  1  bus-wide HREADY; qualifies the address phase.
hreadyout  out  1  slave ready.
hresp  out  1  0 = OKAY, 1 = ERROR.
hrdata  out  32  read data.
mem_valid  out  1  native request valid.
mem_instr  out  1  native instruction-fetch flag.
mem_ready  in  1  native request complete.
mem_addr  out  32  word-aligned native address.
mem_wdata  out  32  native write data, little-endian lanes.
mem_wstrb  out  4  native byte strobes; 0000 = read.
mem_rdata  in  32  native read data, valid with mem_ready.

Behaviour:
- Reset (synchronous, any state): state=IDLE, hreadyout=1, hresp=0, hrdata=0, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, mem_instr=0, timeout counter=0. Effective at the next edge; an in-flight native request is abandoned with mem_valid low.
- Address-phase capture: on a clock edge with hsel & hready & htrans[1] & hreadyout, latch haddr, hwrite, hsize, hprot.
  - IDLE/BUSY or unselected transfers: zero-wait OKAY; state stays IDLE.
- Legality check at capture: hsize>010, half-word with haddr[0]=1, or word with haddr[1:0]!=00 -> ERR1. No native request is issued.
- Legal transfer -> SETUP.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - SETUP (first data-phase cycle): hreadyout=0. If write, latch hwdata lane-mapped into mem_wdata. Drive mem_addr={haddr[31:2],00}, mem_instr=~hprot[0], mem_wstrb (write: strobes from size/offset; read: 0000). Set mem_valid=1 for the next cycle -> ACCESS.
  - ACCESS: mem_valid=1, hreadyout=0. On mem_ready=1: mem_valid=0 next edge, hrdata<=mapped mem_rdata (reads; writes leave hrdata unchanged) -> RESP. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without mem_ready: mem_valid=0 -> ERR1.
  - RESP: hreadyout=1, hresp=0 for one cycle. A new address phase is captured this same cycle (back-to-back); otherwise -> IDLE.
  - ERR1: hresp=1, hreadyout=0 -> ERR2.
  - ERR2: hresp=1, hreadyout=1; a new address phase may be captured; otherwise -> IDLE.
- mem_ready is ignored while mem_valid=0. mem_valid never drops before mem_ready unless a timeout or reset occurs.
- Latency: minimum data phase is 3 cycles (SETUP, ACCESS with mem_ready, RESP); each extra native wait cycle adds 1.
- Byte lanes:
  - Native offset k always maps to mem_wdata[8k+7:8k] and strobe bit k.
  - BIG_ENDIAN_AHB=1: AHB lane for offset k is [31-8k:24-8k]; mem_wdata=byteswap(hwdata), hrdata=byteswap(mem_rdata).
  - BIG_ENDIAN_AHB=0: pass-through.
- Strobes: byte -> 0001<<off; half -> 0011<<off; word -> 1111.

Decomposition:
- Shared package ahb_pkg: HTRANS/HSIZE/HRESP encodings, bridge state enum (IDLE, SETUP, ACCESS, RESP, ERR1, ERR2), and a byteswap32 function.
- One sub-module, ahb_picorv32_lane_map (combinational): inputs hsize, addr[1:0], hwdata, mem_rdata; outputs wstrb, mem_wdata, hrdata, illegal. Parameterised by BIG_ENDIAN_AHB.

Test Plan:
- BE=1, word read 0x40000004, mem_rdata=0x11223344 with mem_ready 2 cycles after mem_valid -> mem_addr=0x40000004, mem_wstrb=0000, hrdata=0x44332211, 4-cycle data phase, OKAY.
- BE=1, byte write 0x40000001, hwdata=0x00AB0000 -> mem_wstrb=0010, mem_wdata[15:8]=0xAB, mem_addr=0x40000000.
- BE=0, half write 0x40000002, hwdata=0xBEEF0000 -> mem_wstrb=1100, mem_wdata=0xBEEF0000.
- Word read at 0x40000002 -> ERR1 then ERR2 (hresp=1, hreadyout 0 then 1); mem_valid never asserted.
- TIMEOUT_CYCLES=8, mem_ready held 0 -> mem_valid high for exactly 8 cycles, then ERROR response; bridge returns to IDLE.
- Back-to-back NONSEQ write then read, with reset pulsed mid-ACCESS on a third transfer -> first two complete OKAY; after reset, mem_valid=0 and hreadyout=1 next cycle.
